uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser_pkg.sv | 26 ++
 rtl/uart_resp_tx.sv | 72 +++++++
 rtl/uart_cmd_parser.sv | 125 ++++++++++++
 tb/tb_uart_cmd_parser.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and FSM state encodings for the UART command parser.
package uart_cmd_parser_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0] ACK_BYTE     = 8'h06;
    localparam logic [7:0] NAK_BYTE     = 8'h15;

    localparam logic [1:0] START_WAIT_LAST = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        D3,
        D2,
        D1,
        D0,
        CHK
    } rx_state_e;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_BUSY
    } tx_state_e;

endpackage

// File: rtl/uart_resp_tx.sv
// One-entry response holding register plus the transmit handshake FSM.
module uart_resp_tx
    import uart_cmd_parser_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_byte,
    input  logic       is_transmitting,
    output logic       transmit,
    output logic [7:0] tx_byte,
    output logic       resp_ovr
);

    tx_state_e  state_q, state_d;
    logic [1:0] wait_q, wait_d;
    logic       pending_q;
    logic [7:0] hold_q;
    logic       send;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d = state_q;
        wait_d  = wait_q;
        send    = 1'b0;
        case (state_q)
            T_IDLE: begin
                if (pending_q && !is_transmitting) begin
                    send    = 1'b1;
                    wait_d  = '0;
                    state_d = T_START;
                end
            end
            T_START: begin
                if (is_transmitting)                state_d = T_BUSY;
                else if (wait_q == START_WAIT_LAST) state_d = T_IDLE;
                else                                wait_d  = wait_q + 2'd1;
            end
            T_BUSY: begin
                if (!is_transmitting) state_d = T_IDLE;
            end
            default: state_d = T_IDLE;
        endcase
    end

    // A push in the cycle the entry is taken wins, so the newer byte stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= T_IDLE;
            wait_q    <= '0;
            pending_q <= 1'b0;
            hold_q    <= '0;
            transmit  <= 1'b0;
            tx_byte   <= '0;
            resp_ovr  <= 1'b0;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            wait_q   <= wait_d;
            transmit <= send;
            if (send) tx_byte <= hold_q;
            if (push) begin
                hold_q    <= push_byte;
                pending_q <= 1'b1;
                if (pending_q && !send) resp_ovr <= 1'b1;
            end else if (send) begin
                pending_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses SYNC/ADDR/D3..D0/CHK frames into register writes and queues ACK/NAK replies.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 120000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    input  logic        recv_error,
    input  logic        is_transmitting,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        resp_ovr
);

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);

    rx_state_e         state_q, state_d;
    logic [7:0]        xor_q, xor_d;
    logic [7:0]        addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              wr_pulse;
    logic              push;
    logic [7:0]        push_byte;

    always_comb begin
        state_d   = state_q;
        xor_d     = xor_q;
        addr_d    = addr_q;
        data_d    = data_q;
        gap_d     = gap_q;
        wr_pulse  = 1'b0;
        push      = 1'b0;
        push_byte = ACK_BYTE;
        if (recv_error) begin
            // A framing error abandons a frame in progress; the coincident byte is dropped.
            if (state_q != IDLE) begin
                state_d   = IDLE;
                gap_d     = '0;
                push      = 1'b1;
                push_byte = NAK_BYTE;
            end
        end else if (received) begin
            gap_d = '0;
            case (state_q)
                IDLE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = ADDR;
                        xor_d   = '0;
                    end
                end
                ADDR: begin
                    addr_d  = rx_byte;
                    xor_d   = xor_q ^ rx_byte;
                    state_d = D3;
                end
                D3, D2, D1, D0: begin
                    data_d  = {data_q[23:0], rx_byte};
                    xor_d   = xor_q ^ rx_byte;
                    state_d = (state_q == D3) ? D2 :
                              (state_q == D2) ? D1 :
                              (state_q == D1) ? D0 : CHK;
                end
                CHK: begin
                    state_d   = IDLE;
                    push      = 1'b1;
                    wr_pulse  = (rx_byte == xor_q);
                    push_byte = (rx_byte == xor_q) ? ACK_BYTE : NAK_BYTE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (gap_q == GAP_LIMIT) begin
                state_d = IDLE;
                gap_d   = '0;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xor_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            gap_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state_q <= state_d;
            xor_q   <= xor_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            wr_en   <= wr_pulse;
            if (wr_pulse) begin
                wr_addr <= addr_q;
                wr_data <= data_q;
            end
        end
    end

    uart_resp_tx u_resp_tx (
        .clk             (clk),
        .rst_n           (rst_n),
        .push            (push),
        .push_byte       (push_byte),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .resp_ovr        (resp_ovr)
    );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a tiny UART transmitter model.
module tb_uart_cmd_parser;

    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        received = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        recv_error = 1'b0;
    logic        is_transmitting = 1'b0;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        resp_ovr;

    int          n_checks = 0;
    int          n_bad = 0;
    int          tx_count = 0;
    int          wr_count = 0;
    logic [7:0]  last_tx = 8'h00;
    logic        force_busy = 1'b0;
    int          busy_cnt = 0;
    int          tx0, wr0;

    uart_cmd_parser #(.TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .received        (received),
        .rx_byte         (rx_byte),
        .recv_error      (recv_error),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .resp_ovr        (resp_ovr)
    );

    always #5 clk = ~clk;

    // UART transmitter model: busy for 5 cycles after each transmit pulse, or while forced.
    initial begin
        forever begin
            @(negedge clk);
            if (transmit) begin
                tx_count = tx_count + 1;
                last_tx  = tx_byte;
                busy_cnt = 5;
            end else if (busy_cnt > 0) begin
                busy_cnt = busy_cnt - 1;
            end
            if (wr_en) wr_count = wr_count + 1;
            is_transmitting = force_busy || (busy_cnt != 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        @(negedge clk);
        received   = 1'b1;
        rx_byte    = b;
        recv_error = err;
        @(negedge clk);
        received   = 1'b0;
        recv_error = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] c);
        send_byte(8'hA5, 1'b0);  idle(1);
        send_byte(a, 1'b0);      idle(1);
        send_byte(d[31:24], 1'b0); idle(1);
        send_byte(d[23:16], 1'b0); idle(1);
        send_byte(d[15:8], 1'b0);  idle(1);
        send_byte(d[7:0], 1'b0);
    endtask

    initial begin
        idle(3);
        check("rst_transmit", {31'd0, transmit}, 32'd0);
        check("rst_wr_en",    {31'd0, wr_en},    32'd0);
        check("rst_resp_ovr", {31'd0, resp_ovr}, 32'd0);
        check("rst_tx_byte",  {24'd0, tx_byte},  32'd0);
        check("rst_wr_addr",  {24'd0, wr_addr},  32'd0);
        check("rst_wr_data",  wr_data,           32'd0);
        rst_n = 1'b1;
        idle(2);

        // Valid frame: 10^DE^AD^BE^EF = 32.
        tx0 = tx_count; wr0 = wr_count;
        send_frame(8'h10, 32'hDEADBEEF, 8'h32);
        check("good_wr_en_none_early", {31'd0, wr_en}, 32'd0);
        idle(1);
        send_byte(8'h32, 1'b0);
        check("good_wr_en_after_chk", {31'd0, wr_en}, 32'd1);
        idle(1);
        check("good_wr_en_one_cycle", {31'd0, wr_en}, 32'd0);
        idle(20);
        check("good_wr_count", wr_count - wr0, 1);
        check("good_wr_addr",  {24'd0, wr_addr}, 32'h10);
        check("good_wr_data",  wr_data, 32'hDEADBEEF);
        check("good_tx_count", tx_count - tx0, 1);
        check("good_tx_byte",  {24'd0, last_tx}, 32'h06);

        // Same frame with a wrong checksum.
        tx0 = tx_count; wr0 = wr_count;
        send_frame(8'h10, 32'hDEADBEEF, 8'h00);
        idle(1);
        send_byte(8'h00, 1'b0);
        idle(20);
        check("bad_wr_count", wr_count - wr0, 0);
        check("bad_tx_count", tx_count - tx0, 1);
        check("bad_tx_byte",  {24'd0, last_tx}, 32'h15);

        // Partial frame abandoned by the gap timeout, then a full frame.
        tx0 = tx_count; wr0 = wr_count;
        send_byte(8'hA5, 1'b0); idle(1);
        send_byte(8'h10, 1'b0); idle(1);
        send_byte(8'hDE, 1'b0);
        idle(TMO);
        send_frame(8'h44, 32'h11223344, 8'h00);
        idle(1);
        send_byte(8'h44 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1'b0);
        idle(20);
        check("tmo_wr_count", wr_count - wr0, 1);
        check("tmo_wr_addr",  {24'd0, wr_addr}, 32'h44);
        check("tmo_wr_data",  wr_data, 32'h11223344);
        check("tmo_tx_count", tx_count - tx0, 1);
        check("tmo_tx_byte",  {24'd0, last_tx}, 32'h06);

        // Leading junk before SYNC is ignored.
        tx0 = tx_count; wr0 = wr_count;
        send_byte(8'h3C, 1'b0); idle(1);
        send_byte(8'h77, 1'b0); idle(1);
        send_frame(8'h10, 32'hDEADBEEF, 8'h32);
        idle(1);
        send_byte(8'h32, 1'b0);
        idle(20);
        check("junk_wr_count", wr_count - wr0, 1);
        check("junk_wr_data",  wr_data, 32'hDEADBEEF);
        check("junk_tx_count", tx_count - tx0, 1);

        // recv_error: ignored in IDLE (coincident SYNC dropped), aborts a frame otherwise.
        tx0 = tx_count; wr0 = wr_count;
        send_byte(8'hA5, 1'b1); idle(1);
        send_byte(8'h10, 1'b0); idle(1);
        send_byte(8'hDE, 1'b0); idle(1);
        send_byte(8'hAD, 1'b0); idle(1);
        send_byte(8'hBE, 1'b0); idle(1);
        send_byte(8'hEF, 1'b0); idle(1);
        send_byte(8'h32, 1'b0);
        idle(20);
        check("err_idle_tx_count", tx_count - tx0, 0);
        check("err_idle_wr_count", wr_count - wr0, 0);
        send_byte(8'hA5, 1'b0); idle(1);
        send_byte(8'h10, 1'b0); idle(1);
        send_byte(8'hDE, 1'b0); idle(1);
        send_byte(8'hAD, 1'b1); idle(1);
        send_byte(8'hBE, 1'b0); idle(1);
        send_byte(8'hEF, 1'b0); idle(1);
        send_byte(8'h32, 1'b0);
        idle(20);
        check("err_frame_wr_count", wr_count - wr0, 0);
        check("err_frame_tx_count", tx_count - tx0, 1);
        check("err_frame_tx_byte",  {24'd0, last_tx}, 32'h15);

        // Two responses while the transmitter is held busy: the later one wins.
        tx0 = tx_count; wr0 = wr_count;
        force_busy = 1'b1;
        idle(2);
        send_frame(8'h10, 32'hDEADBEEF, 8'h00);
        idle(1);
        send_byte(8'h00, 1'b0);
        idle(3);
        send_frame(8'h10, 32'hDEADBEEF, 8'h32);
        idle(1);
        send_byte(8'h32, 1'b0);
        idle(10);
        check("ovr_tx_held",  tx_count - tx0, 0);
        check("ovr_flag",     {31'd0, resp_ovr}, 32'd1);
        force_busy = 1'b0;
        idle(20);
        check("ovr_tx_count", tx_count - tx0, 1);
        check("ovr_tx_byte",  {24'd0, last_tx}, 32'h06);
        check("ovr_wr_count", wr_count - wr0, 1);

        // Asynchronous reset after D2, away from any clock edge.
        send_byte(8'hA5, 1'b0); idle(1);
        send_byte(8'h22, 1'b0); idle(1);
        send_byte(8'h01, 1'b0); idle(1);
        send_byte(8'h02, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_transmit", {31'd0, transmit}, 32'd0);
        check("arst_wr_en",    {31'd0, wr_en},    32'd0);
        check("arst_resp_ovr", {31'd0, resp_ovr}, 32'd0);
        check("arst_tx_byte",  {24'd0, tx_byte},  32'd0);
        check("arst_wr_addr",  {24'd0, wr_addr},  32'd0);
        check("arst_wr_data",  wr_data,           32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        tx0 = tx_count; wr0 = wr_count;
        // 22^01^02^03^04 = 26.
        send_frame(8'h22, 32'h01020304, 8'h26);
        idle(1);
        send_byte(8'h26, 1'b0);
        idle(20);
        check("post_rst_wr_count", wr_count - wr0, 1);
        check("post_rst_wr_addr",  {24'd0, wr_addr}, 32'h22);
        check("post_rst_wr_data",  wr_data, 32'h01020304);
        check("post_rst_tx_count", tx_count - tx0, 1);
        check("post_rst_tx_byte",  {24'd0, last_tx}, 32'h06);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
